// File: rtl/efpga_arbiter.sv
// rtl/efpga_arbiter.sv - round-robin arbiter sharing one eFPGA accelerator port among NumReq cores
// Define EFPGA_ARB_TIMEOUT_EN to build the delay-scaled WAIT timeout counter and res_err_o.
module efpga_arbiter #(
  parameter int NumReq = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [NumReq-1:0]    req_valid_i,
  input  logic [32*NumReq-1:0] req_operand_a_i,
  input  logic [32*NumReq-1:0] req_operand_b_i,
  input  logic [2*NumReq-1:0]  req_operator_i,
  input  logic [4*NumReq-1:0]  req_delay_i,
  output logic [NumReq-1:0]    req_done_o,
  output logic [31:0]          res_a_o,
  output logic [31:0]          res_b_o,
  output logic [31:0]          res_c_o,
  output logic                 res_err_o,
  output logic                 busy_o,
  output logic [2:0]           grant_idx_o,
  output logic [31:0]          eFPGA_operand_a_o,
  output logic [31:0]          eFPGA_operand_b_o,
  output logic [1:0]           eFPGA_operator_o,
  output logic [3:0]           eFPGA_delay_o,
  output logic                 eFPGA_en_o,
  output logic                 eFPGA_write_strobe_o,
  input  logic [31:0]          eFPGA_result_a_i,
  input  logic [31:0]          eFPGA_result_b_i,
  input  logic [31:0]          eFPGA_result_c_i,
  input  logic                 eFPGA_fpga_done_i
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  state_e            state_q, state_d;
  logic [2:0]        rr_ptr_q;
  logic [NumReq-1:0] rot;
  logic [2:0]        rot_off;
  logic [3:0]        pick_sum;
  logic [2:0]        pick_idx;
  logic              pick_valid;
  logic [31:0]       sel_a, sel_b;
  logic [1:0]        sel_op;
  logic [3:0]        sel_dl;
  logic              timeout;

  // Rotate the request vector so bit 0 is the round-robin pointer, then take the lowest set bit.
  assign rot = NumReq'({req_valid_i, req_valid_i} >> rr_ptr_q);

  always_comb begin
    rot_off = '0;
    for (int k = NumReq - 1; k >= 0; k--) begin
      if (rot[k]) rot_off = 3'(k);
    end
    pick_valid = |req_valid_i;
    pick_sum   = {1'b0, rr_ptr_q} + {1'b0, rot_off};
    pick_idx   = (pick_sum >= 4'(NumReq)) ? 3'(pick_sum - 4'(NumReq)) : pick_sum[2:0];
  end

  always_comb begin
    sel_a  = '0;
    sel_b  = '0;
    sel_op = '0;
    sel_dl = '0;
    for (int i = 0; i < NumReq; i++) begin
      if (pick_idx == 3'(i)) begin
        sel_a  = req_operand_a_i[32*i +: 32];
        sel_b  = req_operand_b_i[32*i +: 32];
        sel_op = req_operator_i[2*i +: 2];
        sel_dl = req_delay_i[4*i +: 4];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d              = state_q;
    busy_o               = 1'b0;
    eFPGA_en_o           = 1'b0;
    eFPGA_write_strobe_o = 1'b0;
    req_done_o           = '0;
    case (state_q)
      IDLE: begin
        if (pick_valid) state_d = ISSUE;
      end
      ISSUE: begin
        busy_o               = 1'b1;
        eFPGA_en_o           = 1'b1;
        eFPGA_write_strobe_o = 1'b1;
        state_d              = WAIT;
      end
      WAIT: begin
        busy_o     = 1'b1;
        eFPGA_en_o = 1'b1;
        if (eFPGA_fpga_done_i || timeout) state_d = RESP;
      end
      RESP: begin
        busy_o = 1'b1;
        for (int i = 0; i < NumReq; i++) begin
          req_done_o[i] = (grant_idx_o == 3'(i));
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q          <= '0;
      grant_idx_o       <= '0;
      eFPGA_operand_a_o <= '0;
      eFPGA_operand_b_o <= '0;
      eFPGA_operator_o  <= '0;
      eFPGA_delay_o     <= '0;
      res_a_o           <= '0;
      res_b_o           <= '0;
      res_c_o           <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_valid) begin
            grant_idx_o       <= pick_idx;
            eFPGA_operand_a_o <= sel_a;
            eFPGA_operand_b_o <= sel_b;
            eFPGA_operator_o  <= sel_op;
            eFPGA_delay_o     <= sel_dl;
          end
        end
        WAIT: begin
          // A done arriving together with counter expiry still counts as success.
          if (eFPGA_fpga_done_i) begin
            res_a_o <= eFPGA_result_a_i;
            res_b_o <= eFPGA_result_b_i;
            res_c_o <= eFPGA_result_c_i;
          end else if (timeout) begin
            res_a_o <= '0;
            res_b_o <= '0;
            res_c_o <= '0;
          end
        end
        RESP: begin
          rr_ptr_q <= (grant_idx_o == 3'(NumReq - 1)) ? 3'd0 : grant_idx_o + 3'd1;
        end
        default: ;
      endcase
    end
  end

`ifdef EFPGA_ARB_TIMEOUT_EN
  logic [7:0] cnt_q;
  logic       err_q;

  // Load 16*(delay+1)-1 so WAIT lasts at most 16*(delay+1) cycles.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else if (state_q == ISSUE) begin
      cnt_q <= {eFPGA_delay_o, 4'hF};
    end else if (state_q == WAIT) begin
      if (eFPGA_fpga_done_i) begin
        err_q <= 1'b0;
      end else if (cnt_q == 8'd0) begin
        err_q <= 1'b1;
      end else begin
        cnt_q <= cnt_q - 8'd1;
      end
    end
  end

  assign timeout   = (cnt_q == 8'd0);
  assign res_err_o = err_q;
`else
  assign timeout   = 1'b0;
  assign res_err_o = 1'b0;
`endif

endmodule
